multicycle_ctrl: RTL
====================

# multicycle_ctrl

Sequencing controller for a multicycle build of the MIPS datapath, where one shared memory serves both instruction fetch and data. It sits beside the datapath in place of the single-cycle `controller`. Each instruction advances through a Moore state machine, and the controller drives the datapath's mux selects and write enables per state. It stalls on a memory-ready handshake, traps on unsupported opcodes and counts retired instructions.

## Interface
- `ADDR_W`, default 32: width of the `instret` counter.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: `instr[31:26]`, taken from the instruction register.
- `funct` in 6: `instr[5:0]`.
- `zero` in 1: 1 when the ALU result equals 0.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `pcen` out 1: PC register enable.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `irwrite` out 1: instruction register enable.
- `memwrite` out 1: memory write strobe.
- `regdst` out 1: write-register select (1 = rd).
- `memtoreg` out 1: write-back source (1 = data register).
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A select (0 = PC, 1 = A register).
- `alusrcb` out 2: ALU B select (00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2).
- `pcsrc` out 2: next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `alucontrol` out 3: ALU operation, same encoding as the existing `alu`.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `illegal` out 1: sticky trap flag.
- `instret` out `ADDR_W`: count of retired instructions.

## Operation
Each state lists the outputs it asserts; every output not listed is 0.
- `FETCH`: `alusrcb`=01, `irwrite` and `pcen` only when `mem_ready`=1. Holds in `FETCH` while `mem_ready`=0, otherwise goes to `DECODE`.
- `DECODE`: `alusrcb`=11 (precomputes the branch target). Next state by `op`:
  - 100011 (lw) or 101011 (sw) → `MEMADR`.
  - 000000 → `EXECUTE`, but only if `funct` ∈ {100000, 100010, 100100, 100101, 101010}; otherwise `TRAP`.
  - 000100 → `BRANCH`.
  - 001000 → `ADDIEX`.
  - 000010 → `JUMP`.
  - any other `op` → `TRAP`.
- `MEMADR`: `alusrca`=1, `alusrcb`=10. Next `MEMRD` for lw, `MEMWR` for sw.
- `MEMRD`: `iord`=1. Holds until `mem_ready`, then `MEMWB`.
- `MEMWB`: `memtoreg`=1, `regwrite`=1, `retire`. Next `FETCH`.
- `MEMWR`: `iord`=1, `memwrite`=1 for every cycle until `mem_ready`; on `mem_ready`: `retire`, next `FETCH`.
- `EXECUTE`: `alusrca`=1, `alusrcb`=00, aluop=10 (`alucontrol` decoded from `funct`). Next `ALUWB`.
- `ALUWB`: `regdst`=1, `regwrite`=1, `retire`. Next `FETCH`.
- `BRANCH`: `alusrca`=1, aluop=01, `pcsrc`=01, `pcen`=`zero`, `retire`. Next `FETCH`.
- `ADDIEX`: `alusrca`=1, `alusrcb`=10. Next `ADDIWB`.
- `ADDIWB`: `regwrite`=1, `retire`. Next `FETCH`.
- `JUMP`: `pcsrc`=10, `pcen`=1, `retire`. Next `FETCH`.
- `TRAP`: `illegal`=1, no enables. Absorbing; only `reset` leaves it.

ALU operation selection:
- aluop=00 → `alucontrol`=010 (add).
- aluop=01 → `alucontrol`=110 (subtract).
- aluop=10 → decoded from `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.

Retire counter:
- `instret` increments by 1 on each `retire` cycle.
- Wraps from all-ones to 0 with no flag.

## Timing
- Outputs are a combinational (Moore) decode of the state register. `mem_ready` gates only `pcen`/`irwrite` in `FETCH` and the exit from `MEMRD`/`MEMWR`.
- Latency with `mem_ready` tied high, counting from entering `FETCH` to re-entering `FETCH`:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each cycle of `mem_ready`=0 in `FETCH`, `MEMRD` or `MEMWR` adds exactly one cycle.
- `reset` sampled high at an edge sets state=`FETCH`, `instret`=0, `illegal`=0 on that edge. This applies from any state, including mid-`MEMWR` and `TRAP`.
- While `reset` is high, `pcen`, `irwrite`, `memwrite`, `regwrite` and `retire` are forced to 0.
- Post-reset values of every output are the `FETCH` values: all 0 except `alusrcb`=01 and `alucontrol`=010. `irwrite` and `pcen` follow `mem_ready`.
- `op` and `funct` are sampled only in `DECODE`; later changes have no effect.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum (4-bit: `FETCH`=0 … `JUMP`=11, `TRAP`=12);
  - opcode constants;
  - `funct` constants;
  - aluop codes;
  - `alucontrol` codes.
- Sub-module: the existing `aludec`, instantiated for aluop/`funct` → `alucontrol`.
- Everything else lives in one file: state register, next-state logic, output decode, `instret` counter.

## Test plan
- `reset` pulsed, `mem_ready`=1, lw (`op`=100011) → states 0, 1, 2, 3, 4 then 0; `regwrite`=`memtoreg`=1 only in cycle 5; `instret`=1.
- sw with `mem_ready` low for 3 cycles in `MEMWR` → `memwrite`=1 for 4 consecutive cycles, `iord`=1, a single `retire`.
- beq with `zero`=1, then with `zero`=0 → `pcen`=1 with `pcsrc`=01 in `BRANCH`, then `pcen`=0; each takes 3 cycles.
- `op`=000000 with `funct`=100010 → `alucontrol`=110 in `EXECUTE`. `op`=000000 with `funct`=000111 → `TRAP`, `illegal` stays high for 20 cycles, `reset` clears it.
- `instret` preset to 0xFFFFFFFF via 2^32−1 j instructions (or a forced counter), then one j → `instret`=0.
- `reset` asserted in `MEMWR` with `mem_ready`=0 → `memwrite`=0 the same cycle; `FETCH` and `instret`=0 after the edge.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
//  Package : mips_pkg
//  Shared state, opcode, funct and ALU encodings for the MIPS controllers.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_slt = 3'b111;

  // R-type functions the datapath can actually execute; anything else traps.
  function automatic logic is_rtype_funct(input logic [5:0] fn);
    return (fn == c_fn_add) || (fn == c_fn_sub) || (fn == c_fn_and) ||
           (fn == c_fn_or)  || (fn == c_fn_slt);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aludec.sv
// ============================================================================
//  Module : aludec
//  Maps the controller aluop and the instruction funct field to alucontrol.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = c_alu_add;
    case (aluop)
      c_aluop_add: alucontrol = c_alu_add;
      c_aluop_sub: alucontrol = c_alu_sub;
      c_aluop_funct: begin
        case (funct)
          c_fn_add: alucontrol = c_alu_add;
          c_fn_sub: alucontrol = c_alu_sub;
          c_fn_and: alucontrol = c_alu_and;
          c_fn_or:  alucontrol = c_alu_or;
          c_fn_slt: alucontrol = c_alu_slt;
          default:  alucontrol = c_alu_add;
        endcase
      end
      default: alucontrol = c_alu_add;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module : multicycle_ctrl
//  Moore sequencing controller for the shared-memory multicycle MIPS datapath.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pcen,
  output logic              iord,
  output logic              irwrite,
  output logic              memwrite,
  output logic              regdst,
  output logic              memtoreg,
  output logic              regwrite,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [2:0]        alucontrol,
  output logic              retire,
  output logic              illegal,
  output logic [ADDR_W-1:0] instret
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_is_sw;
  logic [5:0]        r_funct;
  logic [ADDR_W-1:0] r_instret;

  logic [1:0]        w_aluop;
  logic              w_pcen;
  logic              w_irwrite;
  logic              w_memwrite;
  logic              w_regwrite;
  logic              w_retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The instruction fields are only trusted in DECODE; later states use these copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_sw <= 1'b0;
      r_funct <= '0;
    end else if (r_state == DECODE) begin
      r_is_sw <= (op == c_op_sw);
      r_funct <= funct;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + ADDR_W'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:   w_next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          c_op_lw,
          c_op_sw:    w_next_state = MEMADR;
          c_op_rtype: w_next_state = is_rtype_funct(funct) ? EXECUTE : TRAP;
          c_op_beq:   w_next_state = BRANCH;
          c_op_addi:  w_next_state = ADDIEX;
          c_op_j:     w_next_state = JUMP;
          default:    w_next_state = TRAP;
        endcase
      end
      MEMADR:  w_next_state = r_is_sw ? MEMWR : MEMRD;
      MEMRD:   w_next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB:   w_next_state = FETCH;
      MEMWR:   w_next_state = mem_ready ? FETCH : MEMWR;
      EXECUTE: w_next_state = ALUWB;
      ALUWB:   w_next_state = FETCH;
      BRANCH:  w_next_state = FETCH;
      ADDIEX:  w_next_state = ADDIWB;
      ADDIWB:  w_next_state = FETCH;
      JUMP:    w_next_state = FETCH;
      TRAP:    w_next_state = TRAP;
      default: w_next_state = FETCH;
    endcase
  end

  always_comb begin
    w_pcen     = 1'b0;
    iord       = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    w_aluop    = c_aluop_add;
    w_retire   = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = mem_ready;
        w_pcen    = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = mem_ready;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = c_aluop_funct;
      end
      ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = c_aluop_sub;
        pcsrc    = 2'b01;
        w_pcen   = zero;
        w_retire = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      JUMP: begin
        pcsrc    = 2'b10;
        w_pcen   = 1'b1;
        w_retire = 1'b1;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  aludec u_aludec (
    .aluop      (w_aluop),
    .funct      (r_funct),
    .alucontrol (alucontrol)
  );

  // Architectural side effects are suppressed while reset is held.
  assign pcen     = w_pcen     & ~reset;
  assign irwrite  = w_irwrite  & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign retire   = w_retire   & ~reset;
  assign instret  = r_instret;

endmodule

`default_nettype wire
